fifo_bit_serializer: RTL and testbench
======================================

FIFO_BIT_SERIALIZER -- requirements
Module: fifo_bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning FIFO word width in bits (2..16).
REQ-002 SHALL have port clock  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port enable  input  1  permission to start or continue draining the FIFO.
REQ-005 SHALL have port fifo_empty  input  1  FIFO empty flag from the FIFO controller.
REQ-006 SHALL have port fifo_data_valid  input  1  FIFO read-side valid flag; low-then-high marks a completed read.
REQ-007 SHALL have port fifo_rdata  input  WIDTH  FIFO read data at the current read pointer.
REQ-008 SHALL have port bit_tick  input  1  single-cycle bit-rate strobe from the baseband timer.
REQ-009 SHALL have port fifo_read_en  output  1  read request to the FIFO controller.
REQ-010 SHALL have port tx_bit  output  1  serial data, MSB first.
REQ-011 SHALL have port tx_active  output  1  high from leaving IDLE until return to IDLE.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse when a frame ends.

Function
REQ-013 SHALL implement states IDLE, REQ, CAPT, SHIFT, PARITY and DONE, with all outputs registered.
REQ-014 IDLE -> REQ SHALL occur when enable=1 and fifo_empty=0; otherwise the block stays in IDLE.
REQ-015 In REQ, fifo_read_en SHALL be 1; REQ -> CAPT SHALL occur on the first cycle fifo_data_valid=0.
REQ-016 In CAPT, fifo_read_en SHALL stay 1; when fifo_data_valid=1, the block SHALL latch fifo_rdata into the shift register, deassert fifo_read_en on the next cycle, clear the bit counter and go to SHIFT.
REQ-017 In SHIFT, each bit_tick SHALL drive the shift-register MSB onto tx_bit, shift left, zero-fill, and increment the bit counter (width clog2(WIDTH+1)).
REQ-018 tx_bit SHALL hold its value between bit_ticks; bit_tick SHALL be ignored in IDLE, REQ, CAPT and DONE.
REQ-019 The first bit SHALL appear on tx_bit the cycle after the first bit_tick that follows entry to SHIFT; a bit_tick in the CAPT-exit cycle SHALL not be consumed.
REQ-020 After the WIDTH-th tick, the word boundary SHALL be reached: PARITY if TX_PARITY_EN is defined, otherwise the boundary decision.
REQ-021 Boundary decision: enable=1 and fifo_empty=0 -> REQ (back-to-back word, no idle bit); otherwise -> DONE.
REQ-022 Deasserting enable mid-word SHALL not abort the word; it takes effect only at the boundary.
REQ-023 DONE SHALL pulse frame_done for exactly one cycle, drive tx_bit to 0, and return to IDLE.
REQ-024 tx_active SHALL be 0 only in IDLE.
REQ-025 fifo_read_en SHALL never be asserted while in IDLE, SHIFT, PARITY or DONE.

Reset
REQ-026 On reset_n=0, the block SHALL immediately enter IDLE and clear fifo_read_en, tx_bit, tx_active, frame_done, the shift register, the bit counter and the parity accumulator.
REQ-027 Reset mid-word SHALL discard the partial word with no frame_done pulse; the first rising clock edge after reset_n rises SHALL evaluate from IDLE.

Configuration
REQ-028 Macro TX_PARITY_EN defined: the block SHALL accumulate even parity (XOR) over the WIDTH shifted bits, and in PARITY the next bit_tick SHALL drive the parity bit onto tx_bit before the boundary decision, giving WIDTH+1 ticks per word.
REQ-029 Macro TX_PARITY_EN undefined: the PARITY state and the accumulator SHALL not exist, giving WIDTH ticks per word.

Verification
REQ-030 Single word: WIDTH=8, FIFO holds 8'hA5, enable=1, bit_tick every 4 cycles -> tx_bit 1,0,1,0,0,1,0,1; then frame_done pulse; tx_active 1->0.
REQ-031 Back-to-back: FIFO holds 8'hF0, 8'h0F -> 16 bits 1111000000001111 with no gap ticks, exactly two REQ phases, one frame_done.
REQ-032 Read handshake: fifo_data_valid low for 1 cycle after read_en -> fifo_read_en high until the capture cycle, low afterwards, and the captured word equals fifo_rdata at data_valid rise.
REQ-033 Enable drop: enable->0 after 3 ticks of 8'hC3 -> all 8 bits of 8'hC3 sent, then DONE, with no further REQ despite fifo_empty=0.
REQ-034 Reset mid-word: reset_n pulsed low after 4 ticks -> all outputs 0 asynchronously, no frame_done, and restart from IDLE.
REQ-035 TX_PARITY_EN defined, word 8'h07 -> 9th bit equals 1 and frame_done after 9 ticks; macro undefined -> frame_done after 8 ticks.

Source files
------------

// File: rtl/fifo_bit_serializer.sv
// rtl/fifo_bit_serializer.sv - drains FIFO words onto a serial line, MSB first
// Optional even-parity bit per word when TX_PARITY_EN is defined.
`timescale 1ns/1ps
module fifo_bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic             fifo_data_valid,
  input  logic [WIDTH-1:0] fifo_rdata,
  input  logic             bit_tick,
  output logic             fifo_read_en,
  output logic             tx_bit,
  output logic             tx_active,
  output logic             frame_done
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_CAPT, S_SHIFT, S_PARITY, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_CAPT, S_SHIFT, S_DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tx_bit_q, tx_bit_d;
  logic             read_en_q, read_en_d;
  logic             active_q, active_d;
  logic             done_q, done_d;
  logic             boundary;
`ifdef TX_PARITY_EN
  logic             par_q, par_d;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      tx_bit_q  <= 1'b0;
      read_en_q <= 1'b0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      tx_bit_q  <= tx_bit_d;
      read_en_q <= read_en_d;
      active_q  <= active_d;
      done_q    <= done_d;
`ifdef TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    tx_bit_d = tx_bit_q;
    boundary = 1'b0;
`ifdef TX_PARITY_EN
    par_d    = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (enable && !fifo_empty) state_d = S_REQ;
      end
      // The FIFO drops data_valid while it fetches; wait for that before capturing.
      S_REQ: begin
        if (!fifo_data_valid) state_d = S_CAPT;
      end
      S_CAPT: begin
        if (fifo_data_valid) begin
          shreg_d = fifo_rdata;
          cnt_d   = '0;
`ifdef TX_PARITY_EN
          par_d   = 1'b0;
`endif
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_tick) begin
          tx_bit_d = shreg_q[WIDTH-1];
          shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_d    = cnt_q + CW'(1);
`ifdef TX_PARITY_EN
          par_d    = par_q ^ shreg_q[WIDTH-1];
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_PARITY;
`else
          if (cnt_q == CW'(WIDTH - 1)) boundary = 1'b1;
`endif
        end
      end
`ifdef TX_PARITY_EN
      S_PARITY: begin
        if (bit_tick) begin
          tx_bit_d = par_q;
          boundary = 1'b1;
        end
      end
`endif
      S_DONE: begin
        tx_bit_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Enable is only honoured between words, so a word in flight always completes.
    if (boundary) state_d = (enable && !fifo_empty) ? S_REQ : S_DONE;
  end

  assign read_en_d = (state_d == S_REQ) || (state_d == S_CAPT);
  assign active_d  = (state_d != S_IDLE);
  assign done_d    = (state_d == S_DONE);

  assign fifo_read_en = read_en_q;
  assign tx_bit       = tx_bit_q;
  assign tx_active    = active_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_fifo_bit_serializer.sv
// tb/tb_fifo_bit_serializer.sv - self-checking bench for fifo_bit_serializer
// Word expectations follow TX_PARITY_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_fifo_bit_serializer;

  localparam int W = 8;
`ifdef TX_PARITY_EN
  localparam int NB = W + 1;
  localparam logic [31:0] E_A5 = 32'h14A, E_F00F = 32'h3C01E, E_3C = 32'h078,
                          E_C3 = 32'h186, E_55 = 32'h0AA, E_07 = 32'h00F;
`else
  localparam int NB = W;
  localparam logic [31:0] E_A5 = 32'h0A5, E_F00F = 32'h0F00F, E_3C = 32'h03C,
                          E_C3 = 32'h0C3, E_55 = 32'h055, E_07 = 32'h007;
`endif

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable = 1'b0;
  logic         fifo_empty = 1'b1;
  logic         fifo_data_valid = 1'b1;
  logic [W-1:0] fifo_rdata = '0;
  logic         bit_tick = 1'b0;
  logic         fifo_read_en, tx_bit, tx_active, frame_done;

  int nvec = 0;
  int nmis = 0;

  always #5 clock = ~clock;

  fifo_bit_serializer #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_data_valid(fifo_data_valid),
    .fifo_rdata     (fifo_rdata),
    .bit_tick       (bit_tick),
    .fifo_read_en   (fifo_read_en),
    .tx_bit         (tx_bit),
    .tx_active      (tx_active),
    .frame_done     (frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO controller and baseband tick source
  logic [W-1:0] fq[$];
  int   lat = 1;
  int   busy = 0;
  int   tick_div = 0;
  logic rd_prev = 1'b0;

  initial forever begin
    @(posedge clock);
    #1;
    tick_div = (tick_div + 1) % 4;
    bit_tick = (tick_div == 0);
    if (busy > 0) begin
      busy--;
      if (busy == 0) begin
        fifo_rdata      = fq.pop_front();
        fifo_data_valid = 1'b1;
      end
    end else if (fifo_read_en && !rd_prev && fq.size() > 0) begin
      fifo_data_valid = 1'b0;
      busy            = lat;
    end
    rd_prev    = fifo_read_en;
    fifo_empty = (fq.size() == 0);
  end

  // Behavioural model: a word's bits are owed after the FIFO hands it over, one per later tick
  logic m_rd = 0, m_active = 0, m_fd = 0, m_tx = 0, m_seen_low = 0, m_consumed = 0;
  logic m_bits[$];
  logic m_log[$];
  logic d_log[$];

  always @(posedge clock) begin
    m_consumed = 1'b0;
    if (!reset_n) begin
      m_rd = 0; m_active = 0; m_fd = 0; m_tx = 0; m_seen_low = 0;
      m_bits.delete();
    end else if (m_fd) begin
      m_fd = 0; m_active = 0; m_tx = 0;
    end else if (!m_active) begin
      if (enable && !fifo_empty) begin m_active = 1; m_rd = 1; m_seen_low = 0; end
    end else if (m_rd) begin
      if (!fifo_data_valid) m_seen_low = 1;
      else if (m_seen_low) begin
        m_rd = 0;
        for (int i = W - 1; i >= 0; i--) m_bits.push_back(fifo_rdata[i]);
`ifdef TX_PARITY_EN
        m_bits.push_back(^fifo_rdata);
`endif
      end
    end else if (bit_tick) begin
      m_tx = m_bits.pop_front();
      m_log.push_back(m_tx);
      m_consumed = 1'b1;
      if (m_bits.size() == 0) begin
        if (enable && !fifo_empty) begin m_rd = 1; m_seen_low = 0; end
        else m_fd = 1;
      end
    end
  end

  int   fd_cnt = 0;
  int   rd_rise = 0;
  logic rd_seen = 1'b0;

  always @(negedge clock) begin
    if (reset_n) begin
      check("fifo_read_en", 32'(fifo_read_en), 32'(m_rd));
      check("tx_bit",       32'(tx_bit),       32'(m_tx));
      check("tx_active",    32'(tx_active),    32'(m_active));
      check("frame_done",   32'(frame_done),   32'(m_fd));
      if (m_consumed) d_log.push_back(tx_bit);
      if (frame_done) fd_cnt++;
      if (fifo_read_en && !rd_seen) rd_rise++;
      rd_seen = fifo_read_en;
    end else begin
      rd_seen = 1'b0;
    end
  end

  function automatic logic [31:0] pack(input logic q[$], input int from, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) begin
      if (from + i < q.size()) v = {v[30:0], q[from+i]};
      else v = {v[30:0], 1'b0};
    end
    return v;
  endfunction

  int base_d, base_m, base_f, base_r;

  task automatic mark();
    base_d = d_log.size();
    base_m = m_log.size();
    base_f = fd_cnt;
    base_r = rd_rise;
  endtask

  task automatic wait_fd(input int target, input string name);
    int n = 0;
    while (fd_cnt < target && n < 3000) begin @(negedge clock); n++; end
    #1;
    if (fd_cnt < target) begin
      nvec++; nmis++;
      $display("FAIL %s_timeout: frame_done pulses %0d, expected %0d", name, fd_cnt, target);
    end
  endtask

  task automatic wait_bits(input int target, input string name);
    int n = 0;
    while (d_log.size() < target && n < 3000) begin @(negedge clock); n++; end
    #1;
    if (d_log.size() < target) begin
      nvec++; nmis++;
      $display("FAIL %s_timeout: bits seen %0d, expected %0d", name, d_log.size(), target);
    end
  endtask

  task automatic check_run(input string name, input logic [31:0] exp_bits, input int nbits, input int nrd);
    check({name, "_dut_bits"},   pack(d_log, base_d, nbits), exp_bits);
    check({name, "_model_bits"}, pack(m_log, base_m, nbits), exp_bits);
    check({name, "_bit_count"},  32'(d_log.size() - base_d), 32'(nbits));
    check({name, "_frame_done"}, 32'(fd_cnt - base_f), 32'd1);
    check({name, "_req_phases"}, 32'(rd_rise - base_r), 32'(nrd));
    check({name, "_idle"},       32'(tx_active), 32'd0);
  endtask

  task automatic run_words(input string name, input int latency, input logic [31:0] exp_bits,
                           input int nwords);
    lat = latency;
    mark();
    enable = 1'b1;
    wait_fd(base_f + 1, name);
    enable = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    check_run(name, exp_bits, nwords * NB, nwords);
  endtask

  initial begin
    int fdc;
    repeat (3) @(posedge clock);
    #1;
    check("reset_read_en",    32'(fifo_read_en), 32'd0);
    check("reset_tx_bit",     32'(tx_bit),       32'd0);
    check("reset_tx_active",  32'(tx_active),    32'd0);
    check("reset_frame_done", 32'(frame_done),   32'd0);
    reset_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;

    fq.push_back(8'hA5);
    run_words("single_a5", 1, E_A5, 1);

    fq.push_back(8'hF0);
    fq.push_back(8'h0F);
    run_words("b2b_f00f", 2, E_F00F, 2);

    fq.push_back(8'h3C);
    run_words("slow_read_3c", 4, E_3C, 1);

    // Enable drops after three bits; the word must still finish and no new read may start.
    lat = 2;
    fq.push_back(8'hC3);
    fq.push_back(8'h55);
    mark();
    enable = 1'b1;
    wait_bits(base_d + 3, "endrop");
    enable = 1'b0;
    wait_fd(base_f + 1, "endrop");
    repeat (20) @(posedge clock);
    #1;
    check_run("endrop_c3", E_C3, NB, 1);
    check("endrop_fifo_left", 32'(fq.size()), 32'd1);
    run_words("resume_55", 2, E_55, 1);

    // Reset in the middle of a word
    lat = 1;
    fq.push_back(8'h96);
    mark();
    enable = 1'b1;
    wait_bits(base_d + 4, "midreset");
    fdc = fd_cnt;
    reset_n = 1'b0;
    #1;
    check("midreset_read_en",    32'(fifo_read_en), 32'd0);
    check("midreset_tx_bit",     32'(tx_bit),       32'd0);
    check("midreset_tx_active",  32'(tx_active),    32'd0);
    check("midreset_frame_done", 32'(frame_done),   32'd0);
    enable = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    check("midreset_no_done", 32'(fd_cnt - fdc), 32'd0);
    check("midreset_idle",    32'(tx_active),    32'd0);

    fq.push_back(8'h07);
    run_words("after_reset_07", 1, E_07, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
